// File: rtl/rv32i_multicycle_ctrl.sv
// Control sequencer for the multi-cycle RV32I core: walks fetch/decode/execute/memory/writeback,
// with a handshake watchdog, sticky fault cause and cycle/instret counters.
module rv32i_multicycle_ctrl #(
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 exec_fault,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 mem_fault,
    output logic                 imem_req,
    output logic                 ir_en,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 rf_we,
    output logic                 pc_en,
    output logic [2:0]           state,
    output logic [1:0]           fault_cause,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_EXEC    = 2'd1,
        CAUSE_MEM     = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_t;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // The wait counter only has to reach TIMEOUT-1; the cycle after that is the fault.
    localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              WDOG_EN   = (TIMEOUT > 0);

    state_t            cur_state;
    state_t            next_state;
    cause_t            rec_cause;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_legal;
    logic              is_mem;
    logic              is_store;
    logic              writes_rf;
    logic              waiting;
    logic              timed_out;
    logic              active;

    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_OP, OP_OP_IMM,
            OP_LUI, OP_AUIPC, OP_MISC_MEM, OP_SYSTEM: is_legal = 1'b1;
            default:                                  is_legal = 1'b0;
        endcase
    end

    assign is_store  = (opcode == OP_STORE);
    assign is_mem    = (opcode == OP_LOAD) || is_store;
    assign writes_rf = !(is_store || (opcode == OP_BRANCH) || (opcode == OP_MISC_MEM));

    assign waiting   = ((cur_state == S_FETCH)  && !imem_ready) ||
                       ((cur_state == S_MEMORY) && !dmem_ready);
    assign timed_out = WDOG_EN && waiting && (wait_cnt == WAIT_LAST);
    assign active    = (cur_state != S_HALT) && (cur_state != S_FAULT);

    always_comb begin
        next_state = cur_state;
        rec_cause  = CAUSE_NONE;
        imem_req   = 1'b0;
        ir_en      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        pc_en      = 1'b0;
        case (cur_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_en      = 1'b1;
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    next_state = S_FAULT;
                    rec_cause  = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (!is_legal) begin
                    next_state = S_FAULT;
                    rec_cause  = CAUSE_EXEC;
                end else if (opcode == OP_SYSTEM) begin
                    next_state = S_HALT;
                end else begin
                    next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (exec_fault) begin
                    next_state = S_FAULT;
                    rec_cause  = CAUSE_EXEC;
                end else if (is_mem) begin
                    next_state = S_MEMORY;
                end else begin
                    next_state = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                // A completing handshake takes priority over an expiring watchdog.
                if (dmem_ready) begin
                    if (mem_fault) begin
                        next_state = S_FAULT;
                        rec_cause  = CAUSE_MEM;
                    end else begin
                        next_state = S_WRITEBACK;
                    end
                end else if (timed_out) begin
                    next_state = S_FAULT;
                    rec_cause  = CAUSE_TIMEOUT;
                end
            end
            S_WRITEBACK: begin
                pc_en      = 1'b1;
                rf_we      = writes_rf;
                next_state = S_FETCH;
            end
            default: next_state = cur_state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state     <= S_FETCH;
            fault_cause   <= CAUSE_NONE;
            cycle_count   <= '0;
            instret_count <= '0;
            wait_cnt      <= '0;
        end else begin
            cur_state <= next_state;
            if ((cur_state != S_FAULT) && (next_state == S_FAULT)) begin
                fault_cause <= rec_cause;
            end
            if (active) begin
                cycle_count <= cycle_count + CNT_WIDTH'(1);
            end
            if (pc_en) begin
                instret_count <= instret_count + CNT_WIDTH'(1);
            end
            // Cleared whenever not actively waiting, so every FETCH/MEMORY entry starts at zero.
            if (waiting && !timed_out) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl: a cycle-level reference model checked every
// cycle, plus directed instruction sequences with literal expectations.
module tb_rv32i_multicycle_ctrl;

    localparam int CNT_W   = 6;
    localparam int TMO     = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_ILLEGAL  = 7'b1111111;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       opcode = OP_OP_IMM;
    logic             exec_fault = 1'b0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             mem_fault = 1'b0;
    logic             imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en;
    logic [2:0]       state;
    logic [1:0]       fault_cause;
    logic [CNT_W-1:0] cycle_count, instret_count;

    rv32i_multicycle_ctrl #(.CNT_WIDTH(CNT_W), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .exec_fault(exec_fault),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .mem_fault(mem_fault),
        .imem_req(imem_req), .ir_en(ir_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_en(pc_en), .state(state), .fault_cause(fault_cause),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [6:0] op, input logic ir,
                                 input logic dr, input logic mf, input logic ef, input int cycles);
        reset      = rst;
        opcode     = op;
        imem_ready = ir;
        dmem_ready = dr;
        mem_fault  = mf;
        exec_fault = ef;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    // Reference model: state numbers follow the architectural state codes.
    logic [6:0] legal_ops [11] = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_OP,
                                   OP_OP_IMM, OP_LUI, OP_AUIPC, OP_MISC_MEM, OP_SYSTEM};

    function automatic bit legal(input logic [6:0] op);
        for (int i = 0; i < 11; i++) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit retires_to_rf(input logic [6:0] op);
        return !(op == OP_STORE || op == OP_BRANCH || op == OP_MISC_MEM);
    endfunction

    int m_state = 0, m_cause = 0, m_cycles = 0, m_instret = 0, m_wait = 0;
    bit m_valid = 1'b0;

    always @(posedge clock) begin : model
        int nxt;
        int cause;
        if (reset) begin
            m_state = 0; m_cause = 0; m_cycles = 0; m_instret = 0; m_wait = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            nxt   = m_state;
            cause = m_cause;
            if (m_state < 5) m_cycles = (m_cycles + 1) % CNT_MOD;
            case (m_state)
                0: if (imem_ready) nxt = 1;
                   else if (TMO != 0 && m_wait + 1 >= TMO) begin nxt = 6; cause = 3; end
                   else m_wait++;
                1: if (!legal(opcode)) begin nxt = 6; cause = 1; end
                   else if (opcode == OP_SYSTEM) nxt = 5;
                   else nxt = 2;
                2: if (exec_fault) begin nxt = 6; cause = 1; end
                   else if (opcode == OP_LOAD || opcode == OP_STORE) nxt = 3;
                   else nxt = 4;
                3: if (dmem_ready) begin
                       if (mem_fault) begin nxt = 6; cause = 2; end
                       else nxt = 4;
                   end else if (TMO != 0 && m_wait + 1 >= TMO) begin nxt = 6; cause = 3; end
                   else m_wait++;
                4: begin m_instret = (m_instret + 1) % CNT_MOD; nxt = 0; end
                default: nxt = m_state;
            endcase
            if (nxt != m_state) m_wait = 0;
            m_cause = cause;
            m_state = nxt;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            checkOutput("state",         state,         m_state);
            checkOutput("fault_cause",   fault_cause,   m_cause);
            checkOutput("cycle_count",   cycle_count,   m_cycles);
            checkOutput("instret_count", instret_count, m_instret);
            checkOutput("imem_req", imem_req, m_state == 0);
            checkOutput("ir_en",    ir_en,    m_state == 0 && imem_ready);
            checkOutput("dmem_req", dmem_req, m_state == 3);
            checkOutput("dmem_we",  dmem_we,  m_state == 3 && opcode == OP_STORE);
            checkOutput("rf_we",    rf_we,    m_state == 4 && retires_to_rf(opcode));
            checkOutput("pc_en",    pc_en,    m_state == 4);
        end
    end

    int cnt_rf_we = 0, cnt_pc_en = 0, cnt_dmem_req = 0, cnt_dmem_we = 0, cnt_strobe = 0;

    always @(negedge clock) begin
        if (rf_we === 1'b1)    cnt_rf_we++;
        if (pc_en === 1'b1)    cnt_pc_en++;
        if (dmem_req === 1'b1) cnt_dmem_req++;
        if (dmem_we === 1'b1)  cnt_dmem_we++;
        if ((imem_req | ir_en | dmem_req | dmem_we | rf_we | pc_en) !== 1'b0) cnt_strobe++;
    end

    task automatic clearPulses();
        cnt_rf_we = 0; cnt_pc_en = 0; cnt_dmem_req = 0; cnt_dmem_we = 0; cnt_strobe = 0;
    endtask

    logic [6:0] sweep_op  [8] = '{OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_OP, OP_LUI, OP_AUIPC, OP_MISC_MEM};
    int         sweep_len [8] = '{5, 4, 4, 4, 4, 4, 4, 4};
    int         sweep_rf  [8] = '{0, 0, 1, 1, 1, 1, 1, 0};

    initial begin
        applyStimulus(1'b1, OP_OP_IMM, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        checkOutput("reset_state",    state,         0);
        checkOutput("reset_imem_req", imem_req,      1);
        checkOutput("reset_cycles",   cycle_count,   0);
        checkOutput("reset_instret",  instret_count, 0);
        checkOutput("reset_cause",    fault_cause,   0);

        $display("[TB] ADDI with zero-wait memories");
        clearPulses();
        applyStimulus(1'b0, OP_OP_IMM, 1'b1, 1'b1, 1'b0, 1'b0, 4);
        checkOutput("addi_state",   state,         0);
        checkOutput("addi_cycles",  cycle_count,   4);
        checkOutput("addi_instret", instret_count, 1);
        checkOutput("addi_rf_we",   cnt_rf_we,     1);
        checkOutput("addi_pc_en",   cnt_pc_en,     1);

        $display("[TB] LW with dmem_ready on the 4th MEMORY cycle");
        clearPulses();
        applyStimulus(1'b0, OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("lw_in_memory", state, 3);
        applyStimulus(1'b0, OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("lw_wait_boundary", state, 3);
        applyStimulus(1'b0, OP_LOAD, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        checkOutput("lw_state",    state,         0);
        checkOutput("lw_dmem_req", cnt_dmem_req,  4);
        checkOutput("lw_dmem_we",  cnt_dmem_we,   0);
        checkOutput("lw_rf_we",    cnt_rf_we,     1);
        checkOutput("lw_cycles",   cycle_count,   12);
        checkOutput("lw_instret",  instret_count, 2);

        $display("[TB] opcode sweep");
        for (int i = 0; i < 8; i++) begin
            clearPulses();
            applyStimulus(1'b0, sweep_op[i], 1'b1, 1'b1, 1'b0, 1'b0, sweep_len[i]);
            checkOutput("sweep_state", state,     0);
            checkOutput("sweep_rf_we", cnt_rf_we, sweep_rf[i]);
            checkOutput("sweep_pc_en", cnt_pc_en, 1);
        end
        checkOutput("sweep_cycles",  cycle_count,   45);
        checkOutput("sweep_instret", instret_count, 10);

        $display("[TB] SW with mem_fault");
        clearPulses();
        applyStimulus(1'b0, OP_STORE, 1'b1, 1'b1, 1'b1, 1'b0, 3);
        checkOutput("sw_state_mem", state,   3);
        checkOutput("sw_dmem_we",   dmem_we, 1);
        applyStimulus(1'b0, OP_STORE, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        checkOutput("sw_fault_state", state,       6);
        checkOutput("sw_fault_cause", fault_cause, 2);
        checkOutput("sw_cycles",      cycle_count, 49);
        applyStimulus(1'b0, OP_STORE, 1'b1, 1'b1, 1'b1, 1'b1, 5);
        checkOutput("sw_cycles_frozen", cycle_count, 49);
        checkOutput("sw_no_pc_en",      cnt_pc_en,   0);
        checkOutput("sw_cause_sticky",  fault_cause, 2);

        $display("[TB] fetch watchdog");
        applyStimulus(1'b1, OP_OP_IMM, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, OP_OP_IMM, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("tmo_still_fetch", state, 0);
        applyStimulus(1'b0, OP_OP_IMM, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("tmo_state",  state,       6);
        checkOutput("tmo_cause",  fault_cause, 3);
        checkOutput("tmo_cycles", cycle_count, 4);

        applyStimulus(1'b1, OP_OP_IMM, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, OP_OP_IMM, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, OP_OP_IMM, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("late_ready_state", state,       1);
        checkOutput("late_ready_cause", fault_cause, 0);
        applyStimulus(1'b0, OP_OP_IMM, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("late_ready_instret", instret_count, 1);

        $display("[TB] memory watchdog");
        applyStimulus(1'b0, OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("mtmo_still_mem", state, 3);
        applyStimulus(1'b0, OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("mtmo_state", state,       6);
        checkOutput("mtmo_cause", fault_cause, 3);

        $display("[TB] illegal opcode and exec fault");
        applyStimulus(1'b1, OP_ILLEGAL, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, OP_ILLEGAL, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        checkOutput("illegal_state", state,       6);
        checkOutput("illegal_cause", fault_cause, 1);
        applyStimulus(1'b1, OP_OP, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, OP_OP, 1'b1, 1'b1, 1'b0, 1'b1, 3);
        checkOutput("exec_fault_state", state,       6);
        checkOutput("exec_fault_cause", fault_cause, 1);

        $display("[TB] SYSTEM halts");
        applyStimulus(1'b1, OP_SYSTEM, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, OP_SYSTEM, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        checkOutput("halt_state", state, 5);
        clearPulses();
        applyStimulus(1'b0, OP_SYSTEM, 1'b1, 1'b1, 1'b1, 1'b1, 20);
        checkOutput("halt_strobes", cnt_strobe,  0);
        checkOutput("halt_state2",  state,       5);
        checkOutput("halt_cycles",  cycle_count, 2);
        checkOutput("halt_cause",   fault_cause, 0);

        $display("[TB] reset during MEMORY");
        applyStimulus(1'b1, OP_OP_IMM, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, OP_OP_IMM, 1'b1, 1'b1, 1'b0, 1'b0, 4);
        applyStimulus(1'b0, OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        checkOutput("midmem_req", dmem_req, 1);
        applyStimulus(1'b1, OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("midmem_state",    state,         0);
        checkOutput("midmem_cycles",   cycle_count,   0);
        checkOutput("midmem_instret",  instret_count, 0);
        checkOutput("midmem_dmem_req", dmem_req,      0);
        checkOutput("midmem_imem_req", imem_req,      1);

        $display("[TB] counter wrap");
        applyStimulus(1'b0, OP_OP_IMM, 1'b1, 1'b1, 1'b0, 1'b0, 64);
        checkOutput("wrap_state",   state,         0);
        checkOutput("wrap_cycles",  cycle_count,   0);
        checkOutput("wrap_instret", instret_count, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
